corescore_pll_seq: RTL

CORESCORE_PLL_SEQ -- requirements
Module: corescore_pll_seq

---
 rtl/corescore_pll_seq_pkg.sv | 24 ++
 rtl/corescore_sync2.sv | 24 ++
 rtl/corescore_pll_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/corescore_pll_seq_pkg.sv
// Shared definitions for the PLL power-up sequencer: FSM state encoding
// and the sizing function for the single shared cycle counter.
package corescore_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PDOWN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam logic [3:0] RETRY_SAT = 4'd15;

  // One spare bit above the largest terminal count so the counter can never wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/corescore_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the i_clk domain.
module corescore_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/corescore_pll_seq.sv
// PLL power-up sequencer: holds the PLL in powerdown, waits for a stable
// lock with bounded retries, then releases the fabric reset.
module corescore_pll_seq
  import corescore_pll_seq_pkg::*;
#(
  parameter int PD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  input  logic       i_restart,
  output logic       o_pll_powerdown_n,
  output logic       o_rst,
  output logic       o_locked,
  output logic       o_fail,
  output logic [3:0] o_retries
);

  localparam int CW = cnt_width(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] PD_LAST     = CW'(PD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic          lock_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d;
  logic [3:0]    retry_inc;
  logic          counting;
  logic          rst_q;

  corescore_sync2 u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_pll_lock),
    .o_q   (lock_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_PDOWN;
      cnt_q     <= '0;
      retries_q <= '0;
      rst_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      rst_q     <= (state_d != ST_RUN);
    end
  end

  assign retry_inc = (retries_q == RETRY_SAT) ? RETRY_SAT : retries_q + 4'd1;
  assign counting  = (state_q == ST_PDOWN) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE);

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    case (state_q)
      ST_PDOWN: begin
        if (cnt_q == PD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retry_inc;
          state_d   = (32'(retry_inc) == MAX_RETRIES) ? ST_FAIL : ST_PDOWN;
        end
      end
      ST_STABLE: begin
        if (!lock_s)                  state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PDOWN;
    endcase
    if (state_d == ST_RUN && state_q != ST_RUN) retries_d = '0;
    // Restart outranks every transition decided above.
    if (i_restart) begin
      state_d   = ST_PDOWN;
      retries_d = '0;
    end
    if (i_restart || state_d != state_q || !counting) cnt_d = '0;
    else                                             cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    o_pll_powerdown_n = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE) ||
                        (state_q == ST_RUN);
    o_locked          = (state_q == ST_RUN);
    o_fail            = (state_q == ST_FAIL);
    o_rst             = rst_q;
    o_retries         = retries_q;
  end

endmodule
